// File: rtl/gfx256_zread_responder.sv
// Z-buffer line read responder: serves one outstanding 256-bit line request
// from a single-entry line cache or from a Wishbone read cycle.
module gfx256_zread_responder (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cache_enable_i,
  input  logic         z_request_i,
  input  logic [31:5]  z_addr_i,
  input  logic [31:0]  z_sel_i,
  output logic         z_ack_o,
  output logic [255:0] z_data_o,
  output logic         wbm_busy_o,
  input  logic         inv_i,
  input  logic [31:5]  inv_addr_i,
  output logic         m_cyc_o,
  output logic         m_stb_o,
  output logic         m_we_o,
  output logic [31:0]  m_adr_o,
  output logic [31:0]  m_sel_o,
  input  logic [255:0] m_dat_i,
  input  logic         m_ack_i,
  input  logic         m_err_i,
  output logic         err_o
);

  localparam int unsigned LINE_W = 256;
  localparam int unsigned TAG_W  = 27;

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_valid, w_valid_nxt;
  logic [TAG_W-1:0]    r_tag, w_tag_nxt;
  logic [LINE_W-1:0]   r_line, w_line_nxt;
  logic                r_ack, w_ack_nxt;
  logic                r_err, w_err_nxt;
  logic                r_cyc, w_cyc_nxt;
  logic [TAG_W-1:0]    r_adr, w_adr_nxt;
  logic [LINE_W-1:0]   r_data, w_data_nxt;
  logic                w_inv_hit;
  logic                w_hit;
  logic                w_unused_sel;

  // Byte selects are irrelevant: the whole line is always fetched.
  assign w_unused_sel = ^z_sel_i;

  assign w_inv_hit = inv_i & r_valid & (inv_addr_i == r_tag);
  assign w_hit     = cache_enable_i & r_valid & (r_tag == z_addr_i) & ~w_inv_hit;

  // State register and all registered outputs / cache contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_line  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_cyc   <= 1'b0;
      r_adr   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_tag   <= w_tag_nxt;
      r_line  <= w_line_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_cyc   <= w_cyc_nxt;
      r_adr   <= w_adr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next-state, cache update and output next-values.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid & ~w_inv_hit;
    w_tag_nxt   = r_tag;
    w_line_nxt  = r_line;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_cyc_nxt   = r_cyc;
    w_adr_nxt   = r_adr;
    w_data_nxt  = r_data;
    case (r_state)
      ST_IDLE: begin
        if (z_request_i) begin
          if (w_hit) begin
            w_data_nxt  = r_line;
            w_ack_nxt   = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_adr_nxt   = z_addr_i;
            w_cyc_nxt   = 1'b1;
            w_state_nxt = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (m_err_i) begin
          w_data_nxt  = '0;
          w_err_nxt   = 1'b1;
          w_ack_nxt   = 1'b1;
          w_cyc_nxt   = 1'b0;
          w_state_nxt = ST_RESP;
        end else if (m_ack_i) begin
          w_data_nxt  = m_dat_i;
          w_ack_nxt   = 1'b1;
          w_cyc_nxt   = 1'b0;
          w_state_nxt = ST_RESP;
          // A racing invalidate of the line being filled wins over the fill.
          if (cache_enable_i) begin
            if (inv_i && (inv_addr_i == r_adr)) begin
              w_valid_nxt = 1'b0;
            end else begin
              w_valid_nxt = 1'b1;
              w_tag_nxt   = r_adr;
              w_line_nxt  = m_dat_i;
            end
          end
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign z_ack_o    = r_ack;
  assign z_data_o   = r_data;
  assign err_o      = r_err;
  assign m_cyc_o    = r_cyc;
  assign m_stb_o    = r_cyc;
  assign m_we_o     = 1'b0;
  assign m_sel_o    = 32'hFFFF_FFFF;
  assign m_adr_o    = {r_adr, 5'b0};
  assign wbm_busy_o = (r_state != ST_IDLE) | z_request_i;

endmodule

// File: tb/tb_gfx256_zread_responder.sv
// Randomized self-checking bench for gfx256_zread_responder against a
// transaction-level cache model.
module tb_gfx256_zread_responder;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cache_enable_i;
  logic         z_request_i;
  logic [31:5]  z_addr_i;
  logic [31:0]  z_sel_i;
  logic         z_ack_o;
  logic [255:0] z_data_o;
  logic         wbm_busy_o;
  logic         inv_i;
  logic [31:5]  inv_addr_i;
  logic         m_cyc_o, m_stb_o, m_we_o;
  logic [31:0]  m_adr_o, m_sel_o;
  logic [255:0] m_dat_i;
  logic         m_ack_i, m_err_i;
  logic         err_o;

  gfx256_zread_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .cache_enable_i(cache_enable_i),
    .z_request_i(z_request_i), .z_addr_i(z_addr_i), .z_sel_i(z_sel_i),
    .z_ack_o(z_ack_o), .z_data_o(z_data_o), .wbm_busy_o(wbm_busy_o),
    .inv_i(inv_i), .inv_addr_i(inv_addr_i),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_adr_o(m_adr_o), .m_sel_o(m_sel_o), .m_dat_i(m_dat_i),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference cache model
  bit           md_valid;
  logic [31:5]  md_tag;
  logic [255:0] md_line;

  // Observed and expected transaction results
  bit           went_bus, errp, adr_bad, ack_after, busy_ok;
  logic [31:0]  adr;
  logic [255:0] data;
  int           lat;
  bit           exp_bus, exp_err;
  logic [255:0] exp_data;
  int           exp_lat;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Transaction-level expectation; updates the model cache.
  task automatic model_req(input logic [31:5] a, input bit en, input int wt, input bit er,
                           input bit inv_req, input bit inv_ack, input logic [255:0] d);
    bit hit;
    hit = en && md_valid && (md_tag == a) && !inv_req;
    if (inv_req && md_valid && md_tag == a) md_valid = 0;
    if (hit) begin
      exp_bus = 0; exp_data = md_line; exp_err = 0; exp_lat = 1;
    end else begin
      exp_bus = 1; exp_lat = 2 + wt;
      exp_err = er; exp_data = er ? 256'd0 : d;
      if (inv_ack && md_valid && md_tag == a) md_valid = 0;
      if (en && !er) begin
        if (inv_ack) md_valid = 0;
        else begin md_valid = 1; md_tag = a; md_line = d; end
      end
    end
  endtask

  // Drives one request and acts as the Wishbone slave; reports what it saw.
  task automatic run_req(input logic [31:5] a, input bit en, input int wt, input bit er,
                         input bit inv_req, input bit inv_ack, input logic [255:0] d);
    int bc;
    bit done;
    went_bus = 0; adr = '0; data = '0; errp = 0; lat = 0; adr_bad = 0; ack_after = 0;
    bc = 0; done = 0;
    cache_enable_i = en; z_addr_i = a; z_sel_i = $urandom; z_request_i = 1;
    if (inv_req) begin inv_i = 1; inv_addr_i = a; end
    #1 busy_ok = (wbm_busy_o === 1'b1);
    while (!done && lat < 40) begin
      @(posedge clk_i); #1; lat++;
      inv_i = 0; m_ack_i = 0; m_err_i = 0;
      if (z_ack_o === 1'b1) begin
        data = z_data_o; errp = err_o; done = 1; z_request_i = 0;
      end else if (m_cyc_o === 1'b1) begin
        if (!went_bus) adr = m_adr_o;
        else if (m_adr_o !== adr) adr_bad = 1;
        if (m_stb_o !== 1'b1 || m_we_o !== 1'b0) adr_bad = 1;
        went_bus = 1;
        if (bc == wt) begin
          m_dat_i = er ? rand256() : d;
          if (er) begin m_err_i = 1; m_ack_i = 1'($urandom % 2); end
          else m_ack_i = 1;
          if (inv_ack) begin inv_i = 1; inv_addr_i = a; end
        end
        bc++;
      end
    end
    if (!done) lat = 999;
    z_request_i = 0;
    @(posedge clk_i); #1;
    ack_after = z_ack_o;
  endtask

  task automatic do_inv(input logic [31:5] a);
    inv_i = 1; inv_addr_i = a;
    @(posedge clk_i); #1;
    inv_i = 0;
    if (md_valid && md_tag == a) md_valid = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; cache_enable_i = 1; z_request_i = 0; z_addr_i = '0; z_sel_i = '0;
    inv_i = 0; inv_addr_i = '0; m_dat_i = '0; m_ack_i = 0; m_err_i = 0;
    md_valid = 0; md_tag = '0; md_line = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    @(posedge clk_i); #1;
    n_tests++; if ({z_ack_o, m_cyc_o, m_stb_o, m_we_o, err_o, wbm_busy_o} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 000000", {z_ack_o, m_cyc_o, m_stb_o, m_we_o, err_o, wbm_busy_o}); end
    n_tests++; if (z_data_o !== 256'd0 || m_adr_o !== 32'd0) begin n_fail++; $display("FAIL reset_data data=%h adr=%h want 0", z_data_o, m_adr_o); end
    n_tests++; if (m_sel_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_sel got %h want ffffffff", m_sel_o); end
  endtask

  task automatic test_cold_miss();
    logic [255:0] d;
    d = rand256();
    model_req(27'h0000040, 1, 2, 0, 0, 0, d);
    run_req(27'h0000040, 1, 2, 0, 0, 0, d);
    n_tests++; if (went_bus !== 1'b1) begin n_fail++; $display("FAIL cold_bus got %0b want 1", went_bus); end
    n_tests++; if (adr !== 32'h00000800) begin n_fail++; $display("FAIL cold_adr got %h want 00000800", adr); end
    n_tests++; if (adr_bad !== 1'b0) begin n_fail++; $display("FAIL cold_bus_stable got %0b want 0", adr_bad); end
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL cold_latency got %0d want 4", lat); end
    n_tests++; if (data !== d) begin n_fail++; $display("FAIL cold_data got %h want %h", data, d); end
    n_tests++; if (ack_after !== 1'b0 || errp !== 1'b0) begin n_fail++; $display("FAIL cold_pulse ack_after=%0b err=%0b want 0 0", ack_after, errp); end
    n_tests++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL cold_busy got %0b want 1", busy_ok); end
  endtask

  task automatic test_hit();
    model_req(27'h0000040, 1, 0, 0, 0, 0, '0);
    run_req(27'h0000040, 1, 0, 0, 0, 0, '0);
    n_tests++; if (went_bus !== 1'b0) begin n_fail++; $display("FAIL hit_bus got %0b want 0", went_bus); end
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL hit_latency got %0d want 1", lat); end
    n_tests++; if (data !== exp_data) begin n_fail++; $display("FAIL hit_data got %h want %h", data, exp_data); end
  endtask

  task automatic test_invalidate();
    logic [255:0] d;
    do_inv(27'h0000040);
    d = rand256();
    model_req(27'h0000040, 1, 1, 0, 0, 0, d);
    run_req(27'h0000040, 1, 1, 0, 0, 0, d);
    n_tests++; if (went_bus !== 1'b1) begin n_fail++; $display("FAIL inv_bus got %0b want 1", went_bus); end
    d = rand256();
    do_inv(27'h0000040);
    model_req(27'h0000040, 1, 0, 0, 0, 1, d);
    run_req(27'h0000040, 1, 0, 0, 0, 1, d);
    n_tests++; if (data !== d || went_bus !== 1'b1) begin n_fail++; $display("FAIL inv_ack_data got %h bus=%0b want %h bus=1", data, went_bus, d); end
    model_req(27'h0000040, 1, 0, 0, 0, 0, d);
    run_req(27'h0000040, 1, 0, 0, 0, 0, d);
    n_tests++; if (went_bus !== 1'b1) begin n_fail++; $display("FAIL inv_ack_refetch got bus=%0b want 1", went_bus); end
    model_req(27'h0000040, 1, 0, 0, 1, 0, d);
    run_req(27'h0000040, 1, 0, 0, 1, 0, d);
    n_tests++; if (went_bus !== 1'b1) begin n_fail++; $display("FAIL inv_same_cycle_hit got bus=%0b want 1", went_bus); end
  endtask

  task automatic test_error();
    logic [255:0] d;
    d = rand256();
    model_req(27'h0000123, 1, 1, 1, 0, 0, d);
    run_req(27'h0000123, 1, 1, 1, 0, 0, d);
    n_tests++; if (errp !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %0b want 1", errp); end
    n_tests++; if (data !== 256'd0 || lat !== 3) begin n_fail++; $display("FAIL err_data got %h lat=%0d want 0 lat=3", data, lat); end
    model_req(27'h0000123, 1, 0, 0, 0, 0, d);
    run_req(27'h0000123, 1, 0, 0, 0, 0, d);
    n_tests++; if (went_bus !== 1'b1 || errp !== 1'b0) begin n_fail++; $display("FAIL err_refetch bus=%0b err=%0b want 1 0", went_bus, errp); end
  endtask

  task automatic test_cache_disable();
    logic [255:0] d;
    for (int i = 0; i < 2; i++) begin
      d = rand256();
      model_req(27'h0000077, 0, 0, 0, 0, 0, d);
      run_req(27'h0000077, 0, 0, 0, 0, 0, d);
      n_tests++; if (went_bus !== 1'b1 || data !== d) begin n_fail++; $display("FAIL disable_miss%0d bus=%0b data=%h want 1 %h", i, went_bus, data, d); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit bad;
    cache_enable_i = 1; z_addr_i = 27'h0000555; z_request_i = 1;
    n = 0;
    while (m_cyc_o !== 1'b1 && n < 10) begin @(posedge clk_i); #1; n++; end
    n_tests++; if (m_cyc_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_cyc_start got %0b want 1", m_cyc_o); end
    #3 rst_i = 1;
    #1;
    n_tests++; if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop cyc=%0b stb=%0b want 0 0", m_cyc_o, m_stb_o); end
    z_request_i = 0; md_valid = 0;
    @(posedge clk_i); #1 rst_i = 0;
    m_ack_i = 1; m_dat_i = rand256();
    bad = 0;
    repeat (4) begin
      @(posedge clk_i); #1;
      m_ack_i = 0;
      if (z_ack_o !== 1'b0 || m_cyc_o !== 1'b0) bad = 1;
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL rstmid_late_ack got ack/cyc activity want none"); end
  endtask

  task automatic test_random();
    logic [31:5] a, pool [4];
    logic [255:0] d;
    bit en, er, ir, ia;
    int wt;
    pool[0] = 27'h0000040; pool[1] = 27'h0000041; pool[2] = 27'h7FFFFFF; pool[3] = 27'h0000000;
    for (int it = 0; it < 80; it++) begin
      a = pool[$urandom % 4];
      if ($urandom % 6 == 0) begin
        do_inv(($urandom % 2) ? a : 27'($urandom));
      end else begin
        en = ($urandom % 5) != 0; er = ($urandom % 8) == 0;
        ir = ($urandom % 8) == 0; ia = ($urandom % 8) == 0;
        wt = $urandom_range(0, 3); d = rand256();
        model_req(a, en, wt, er, ir, ia, d);
        run_req(a, en, wt, er, ir, ia, d);
        n_tests++;
        if (went_bus !== exp_bus || data !== exp_data || errp !== exp_err || lat !== exp_lat ||
            adr_bad !== 1'b0 || ack_after !== 1'b0 || (exp_bus && adr !== {a, 5'b0})) begin
          n_fail++;
          $display("FAIL random%0d bus=%0b err=%0b lat=%0d adr=%h data=%h want bus=%0b err=%0b lat=%0d adr=%h data=%h",
                   it, went_bus, errp, lat, adr, data, exp_bus, exp_err, exp_lat, {a, 5'b0}, exp_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_hit();
    test_invalidate();
    test_error();
    test_cache_disable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
